order_uart_tx: RTL and testbench

Serializes risk-approved order actions back onto a UART line, the transmit counterpart of the market-data UART receive path. Sits after the risk limiter in the stage-6 top: each `act_valid` pulse (side, price, qty) is queued in a small FIFO, framed into a fixed binary message and shifted out 8N1. It provides the PL's outbound order channel and keeps frame and drop counters for ILA observation.

---
 rtl/order_tx_pkg.sv | 47 ++++
 rtl/uart_tx_byte.sv | 98 +++++++++
 rtl/order_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_order_uart_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/order_tx_pkg.sv
// Shared types and frame constants for the order UART transmit path.
// Frame length depends on ORDER_TX_CHECKSUM_EN (adds a trailing XOR checksum byte).
package order_tx_pkg;

  localparam logic [7:0] ORDER_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ORDER_SIDE_BUY  = 8'h00;
  localparam logic [7:0] ORDER_SIDE_SELL = 8'h01;

`ifdef ORDER_TX_CHECKSUM_EN
  localparam int unsigned ORDER_FRAME_BYTES = 11;
`else
  localparam int unsigned ORDER_FRAME_BYTES = 10;
`endif

  typedef struct packed {
    logic        side;
    logic [31:0] price;
    logic [31:0] qty;
  } order_action_t;

  typedef enum logic [1:0] {FrIdle, FrLoad, FrSend, FrDone} frame_state_e;
  typedef enum logic [1:0] {BtIdle, BtStart, BtData, BtStop} byte_state_e;

  // Byte idx of the frame; price and qty go out big-endian, idx 10 is the checksum.
  function automatic logic [7:0] order_frame_byte(input logic [3:0]  idx,
                                                  input logic        side,
                                                  input logic [31:0] price,
                                                  input logic [31:0] qty,
                                                  input logic [7:0]  csum);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ORDER_SYNC_BYTE;
      4'd1:    b = side ? ORDER_SIDE_SELL : ORDER_SIDE_BUY;
      4'd2:    b = price[31:24];
      4'd3:    b = price[23:16];
      4'd4:    b = price[15:8];
      4'd5:    b = price[7:0];
      4'd6:    b = qty[31:24];
      4'd7:    b = qty[23:16];
      4'd8:    b = qty[15:8];
      4'd9:    b = qty[7:0];
      default: b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request in the last STOP cycle chains the next
// byte with no idle gap, so a frame streams out back-to-back.
module uart_tx_byte
  import order_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       serial,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  byte_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        bit_last;

  assign bit_last = (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BtIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      BtIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = BtStart;
          shift_d = data;
        end
      end
      BtStart: begin
        if (bit_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = BtData;
        end
      end
      BtData: begin
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = BtStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      BtStop: begin
        if (bit_last) begin
          cnt_d = '0;
          if (start) begin
            state_d = BtStart;
            shift_d = data;
          end else begin
            state_d = BtIdle;
          end
        end
      end
    endcase
  end

  // Line level is registered from the next state so it changes on the same edge.
  always_comb begin
    unique case (state_d)
      BtStart: serial_d = 1'b0;
      BtData:  serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    serial = serial_q;
    busy   = (state_q != BtIdle);
    done   = (state_q == BtStop) && bit_last;
  end

endmodule

// File: rtl/order_uart_tx.sv
// Order action FIFO + frame FSM driving uart_tx_byte; keeps frame/drop counters.
// Define ORDER_TX_CHECKSUM_EN to append an XOR checksum of bytes 1..9 as byte 10.
module order_uart_tx
  import order_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_side,
  input  logic [31:0] in_price,
  input  logic [31:0] in_qty,
  output logic        uart_tx_serial,
  output logic        tx_busy,
  output logic [31:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [3:0]  LastIdx = 4'(ORDER_FRAME_BYTES - 1);

  // FIFO
  order_action_t   mem_q [FIFO_DEPTH];
  order_action_t   in_action, head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty, fifo_full, push, pop, drop;

  assign in_action  = '{side: in_side, price: in_price, qty: in_qty};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push       = in_valid && (!fifo_full || pop);
  assign drop       = in_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_action;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Frame FSM and datapath
  frame_state_e fr_state_q, fr_state_d;
  logic [3:0]   idx_q, idx_d, next_idx;
  logic         side_q, side_d;
  logic [31:0]  price_q, price_d, qty_q, qty_d;
  logic [31:0]  frame_count_q, frame_count_d;
  logic [15:0]  drop_count_q, drop_count_d;
  logic [7:0]   csum_val;
  logic         byte_start, byte_busy, byte_done;
  logic [7:0]   byte_data;

`ifdef ORDER_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign csum_val = csum_q;
`else
  assign csum_val = 8'h00;
`endif

  assign next_idx = idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fr_state_q    <= FrIdle;
      idx_q         <= '0;
      side_q        <= 1'b0;
      price_q       <= '0;
      qty_q         <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
`ifdef ORDER_TX_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      fr_state_q    <= fr_state_d;
      idx_q         <= idx_d;
      side_q        <= side_d;
      price_q       <= price_d;
      qty_q         <= qty_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
`ifdef ORDER_TX_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  always_comb begin
    fr_state_d = fr_state_q;
    unique case (fr_state_q)
      FrIdle: if (!fifo_empty) fr_state_d = FrLoad;
      FrLoad: fr_state_d = FrSend;
      FrSend: if (byte_done && (idx_q == LastIdx)) fr_state_d = FrDone;
      FrDone: fr_state_d = fifo_empty ? FrIdle : FrLoad;
    endcase
  end

  always_comb begin
    pop           = 1'b0;
    byte_start    = 1'b0;
    byte_data     = order_frame_byte(next_idx, side_q, price_q, qty_q, csum_val);
    idx_d         = idx_q;
    side_d        = side_q;
    price_d       = price_q;
    qty_d         = qty_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
`ifdef ORDER_TX_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    unique case (fr_state_q)
      FrIdle: ;
      FrLoad: begin
        // Sync byte is constant, so the engine can start while the head is popped.
        pop        = 1'b1;
        byte_start = 1'b1;
        byte_data  = ORDER_SYNC_BYTE;
        idx_d      = '0;
        side_d     = head.side;
        price_d    = head.price;
        qty_d      = head.qty;
`ifdef ORDER_TX_CHECKSUM_EN
        csum_d     = '0;
`endif
      end
      FrSend: begin
        if (byte_done) begin
          idx_d = next_idx;
          if (idx_q != LastIdx) begin
            byte_start = 1'b1;
`ifdef ORDER_TX_CHECKSUM_EN
            if (next_idx <= 4'd9) csum_d = csum_q ^ byte_data;
`endif
          end
        end
      end
      FrDone: frame_count_d = frame_count_q + 32'd1;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .serial(uart_tx_serial),
    .busy  (byte_busy),
    .done  (byte_done)
  );

  assign tx_busy     = (fr_state_q != FrIdle) || !fifo_empty || byte_busy;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_order_uart_tx.sv
// Scoreboard bench for order_uart_tx: a line decoder rebuilds frames and
// compares them against actions queued when they were strobed.
module tb_order_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef ORDER_TX_CHECKSUM_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned FRAME_CYC = FB * 10 * CPB;

  typedef struct packed {
    logic        side;
    logic [31:0] price;
    logic [31:0] qty;
  } act_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_side = 1'b0;
  logic [31:0] in_price = '0;
  logic [31:0] in_qty = '0;
  logic        uart_tx_serial, tx_busy;
  logic [31:0] frame_count;
  logic [15:0] drop_count;

  act_t        sb[$];
  int unsigned starts[$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b1;

  order_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_side       (in_side),
    .in_price      (in_price),
    .in_qty        (in_qty),
    .uart_tx_serial(uart_tx_serial),
    .tx_busy       (tx_busy),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_frame(input act_t a);
    logic [7:0]   b[11];
    logic [7:0]   x;
    logic [127:0] v;
    b[0] = 8'hA5;
    b[1] = a.side ? 8'h01 : 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[2+i] = a.price[31-8*i -: 8];
      b[6+i] = a.qty[31-8*i -: 8];
    end
    x = 8'h00;
    for (int i = 1; i <= 9; i++) x = x ^ b[i];
    b[10] = x;
    v = '0;
    for (int i = 0; i < int'(FB); i++) v = {v[119:0], b[i]};
    return v;
  endfunction

  // Line decoder: samples every cycle of every bit, so width and level are both checked.
  initial begin
    logic [7:0]   by;
    logic [127:0] fr;
    int unsigned  nb, s, fs;
    bit           clean;
    logic         first;
    nb = 0; fr = '0; fs = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && uart_tx_serial === 1'b0) begin
        s = cyc; clean = 1'b1; by = '0; first = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < int'(CPB); k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) first = uart_tx_serial;
            else if (uart_tx_serial !== first) clean = 1'b0;
            if (b == 0 && uart_tx_serial !== 1'b0) clean = 1'b0;
            if (b == 9 && uart_tx_serial !== 1'b1) clean = 1'b0;
            if (b >= 1 && b <= 8 && k == 0) by[b-1] = uart_tx_serial;
          end
        end
        check_eq("bit_width", clean, 1'b1);
        if (nb == 0) begin
          fs = s;
          starts.push_back(s);
        end else begin
          check_eq("byte_gap", s, fs + nb * 10 * CPB);
        end
        fr = {fr[119:0], by};
        nb++;
        if (nb == FB) begin
          check_eq("sb_nonempty", (sb.size() != 0), 1'b1);
          if (sb.size() != 0) check_eq("frame", fr, exp_frame(sb.pop_front()));
          nb = 0;
          fr = '0;
        end
      end
    end
  end

  task automatic send(input logic side, input logic [31:0] price, input logic [31:0] qty,
                      input bit keep, output int unsigned acc);
    act_t a;
    a.side = side; a.price = price; a.qty = qty;
    in_valid = 1'b1; in_side = side; in_price = price; in_qty = qty;
    acc = cyc + 1;
    if (keep) sb.push_back(a);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", (n < budget), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned acc, s0;
    bit          ok;
    int          n;

    repeat (3) @(negedge clk);
    check_eq("rst_serial", uart_tx_serial, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_fc", frame_count, 32'd0);
    check_eq("rst_dc", drop_count, 16'd0);
    rst_n = 1'b1;

    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx_serial !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check_eq("idle_high", ok, 1'b1);

    // Single action: latency, content and frame_count update point
    starts.delete();
    send(1'b1, 32'h0000_1234, 32'h0000_0064, 1'b1, acc);
    n = 0;
    while (starts.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", (starts.size() != 0), 1'b1);
    s0 = (starts.size() != 0) ? starts[0] : acc + 2;
    check_eq("start_lat", s0, acc + 2);
    while (cyc < s0 + FRAME_CYC) @(negedge clk);
    check_eq("fc_at_end", frame_count, 32'd0);
    @(negedge clk);
    check_eq("fc_after", frame_count, 32'd1);
    drain(2000);
    check_eq("busy_after1", tx_busy, 1'b0);

    // Three back-to-back actions: order and 2-cycle inter-frame gap
    starts.delete();
    send(1'b0, 32'h8000_0001, 32'h0000_00FF, 1'b1, acc);
    send(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, acc);
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, acc);
    drain(5000);
    check_eq("three_starts", starts.size(), 3);
    if (starts.size() == 3) begin
      check_eq("gap12", starts[1] - (starts[0] + FRAME_CYC), 2);
      check_eq("gap23", starts[2] - (starts[1] + FRAME_CYC), 2);
    end
    check_eq("fc_three", frame_count, 32'd4);
    check_eq("dc_three", drop_count, 16'd0);

    // Six strobes into a depth-4 FIFO: the LOAD pop frees one slot, the sixth drops
    for (int i = 0; i < 6; i++)
      send(i[0], 32'hA000_0000 + i, 32'h0000_0100 * (i + 1), (i < 5), acc);
    drain(10000);
    check_eq("dc_one", drop_count, 16'd1);
    check_eq("fc_nine", frame_count, 32'd9);

    // Reset in the middle of byte 3
    mon_en = 1'b0;
    send(1'b1, 32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, acc);
    s0 = acc + 2;
    while (cyc < s0 + 3 * 10 * CPB + 10) @(negedge clk);
    check_eq("busy_pre_rst", tx_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_serial", uart_tx_serial, 1'b1);
    check_eq("mid_rst_busy", tx_busy, 1'b0);
    check_eq("mid_rst_fc", frame_count, 32'd0);
    check_eq("mid_rst_dc", drop_count, 16'd0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx_serial !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
    end
    check_eq("quiet_after_rst", ok, 1'b1);

    // Saturate drop_count with continuous overflow strobes
    in_valid = 1'b1; in_side = 1'b0; in_price = 32'h1; in_qty = 32'h2;
    repeat (66000) @(negedge clk);
    check_eq("dc_sat", drop_count, 16'hFFFF);
    repeat (50) @(negedge clk);
    check_eq("dc_hold", drop_count, 16'hFFFF);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("sat_rst_dc", drop_count, 16'd0);
    check_eq("sat_rst_serial", uart_tx_serial, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame after reset recovery
    mon_en = 1'b1;
    starts.delete();
    send(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, acc);
    drain(2000);
    check_eq("fc_recover", frame_count, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
